// File: rtl/multi_debouncer.sv
// Multi-channel switch debouncer: per-channel 2FF synchroniser, lockout or
// stable-window filter, registered rise/fall strobes and an optional long-press strobe.
module multi_debouncer #(
  parameter int unsigned      NCH         = 4,
  parameter int unsigned      TIME_PERIOD = 75000,
  parameter int unsigned      MODE        = 0,
  parameter logic [NCH-1:0]   ACTIVE_LOW  = {NCH{1'b0}},
  parameter int unsigned      HOLD_PERIOD = 0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [NCH-1:0] i_btn,
  output logic [NCH-1:0] o_debounced,
  output logic [NCH-1:0] o_rise,
  output logic [NCH-1:0] o_fall,
  output logic [NCH-1:0] o_long
);

  localparam int unsigned   TW   = (TIME_PERIOD > 1) ? $clog2(TIME_PERIOD) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIME_PERIOD - 1);

  // Inversion happens before the first flop so every later stage sees 1 = pressed.
  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_sync2;

  // NOTE: sequential state is always updated with <= so every flop samples
  // the pre-edge value of its inputs, regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_btn ^ ACTIVE_LOW;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [TW-1:0] r_cnt;
    logic          r_deb;
    logic          r_rise;
    logic          r_fall;
    logic [TW-1:0] w_cnt_nxt;
    logic          w_deb_nxt;

    if (MODE == 0) begin : g_lockout
      // Counter is a down-counting hold-off timer armed on each accepted edge.
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      always_comb begin
        w_cnt_nxt = r_cnt;
        w_deb_nxt = r_deb;
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (r_sync2[ch] != r_deb) begin
          w_deb_nxt = r_sync2[ch];
          w_cnt_nxt = TMAX;
        end
      end
    end else begin : g_stable
      // Counter measures how long the synchronised input has disagreed with the output.
      always_comb begin
        w_cnt_nxt = '0;
        w_deb_nxt = r_deb;
        if (r_sync2[ch] != r_deb) begin
          if (r_cnt == TMAX) begin
            w_deb_nxt = r_sync2[ch];
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_cnt  <= '0;
        r_deb  <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_deb  <= w_deb_nxt;
        r_rise <= w_deb_nxt & ~r_deb;
        r_fall <= ~w_deb_nxt & r_deb;
      end
    end

    assign o_debounced[ch] = r_deb;
    assign o_rise[ch]      = r_rise;
    assign o_fall[ch]      = r_fall;

    if (HOLD_PERIOD > 0) begin : g_long
      localparam int unsigned   HW   = $clog2(HOLD_PERIOD + 1);
      localparam logic [HW-1:0] HMAX = HW'(HOLD_PERIOD);

      logic [HW-1:0] r_hold;
      logic          r_long;

      // r_hold counts pressed cycles including the current one; saturation
      // guarantees a single o_long per press.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_hold <= '0;
          r_long <= 1'b0;
        end else if (!w_deb_nxt) begin
          r_hold <= '0;
          r_long <= 1'b0;
        end else if (r_hold != HMAX) begin
          r_hold <= r_hold + 1'b1;
          r_long <= (r_hold == HMAX - 1'b1);
        end else begin
          r_long <= 1'b0;
        end
      end

      assign o_long[ch] = r_long;
    end else begin : g_no_long
      assign o_long[ch] = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: lockout, stable, active-low, long-press
// and mid-window reset behaviour across three parameterisations.
module tb_multi_debouncer;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_a, btn_b, btn_c;
  logic [3:0] deb_a, rise_a, fall_a, long_a;
  logic [3:0] deb_b, rise_b, fall_b, long_b;
  logic [3:0] deb_c, rise_c, fall_c, long_c;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  typedef struct packed {
    logic [3:0] btn;
    logic [3:0] deb;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl [1:34];

  multi_debouncer #(.NCH(4), .TIME_PERIOD(8), .MODE(0), .ACTIVE_LOW(4'b0100), .HOLD_PERIOD(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn_a),
    .o_debounced(deb_a), .o_rise(rise_a), .o_fall(fall_a), .o_long(long_a));

  multi_debouncer #(.NCH(4), .TIME_PERIOD(8), .MODE(1), .ACTIVE_LOW(4'b0000), .HOLD_PERIOD(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn_b),
    .o_debounced(deb_b), .o_rise(rise_b), .o_fall(fall_b), .o_long(long_b));

  multi_debouncer #(.NCH(4), .TIME_PERIOD(4), .MODE(0), .ACTIVE_LOW(4'b0000), .HOLD_PERIOD(20)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn_c),
    .o_debounced(deb_c), .o_rise(rise_c), .o_fall(fall_c), .o_long(long_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, edge_n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Edge numbering restarts at 0 right after release; the next posedge is edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    btn_a = 4'b0100;
    btn_b = 4'b0000;
    btn_c = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic set_rows(input int first, input int last,
                          input logic [3:0] b, input logic [3:0] d,
                          input logic [3:0] r, input logic [3:0] f);
    for (int e = first; e <= last; e++) tbl[e] = '{b, d, r, f};
  endtask

  initial begin
    // Row e: btn present at edge e, outputs expected after edge e (TIME_PERIOD=8).
    // ch2 is active-low: raw 1 = released, raw 0 = pressed.
    set_rows( 1,  9, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    set_rows(10, 11, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
    set_rows(12, 12, 4'b0101, 4'b0001, 4'b0001, 4'b0000);
    set_rows(13, 13, 4'b0101, 4'b0001, 4'b0000, 4'b0000);
    set_rows(14, 15, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    set_rows(16, 16, 4'b0000, 4'b0101, 4'b0100, 4'b0000);
    set_rows(17, 19, 4'b0000, 4'b0101, 4'b0000, 4'b0000);
    set_rows(20, 20, 4'b0000, 4'b0100, 4'b0000, 4'b0001);
    set_rows(21, 29, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    set_rows(30, 31, 4'b1001, 4'b0100, 4'b0000, 4'b0000);
    set_rows(32, 32, 4'b1001, 4'b1101, 4'b1001, 4'b0000);
    set_rows(33, 34, 4'b1001, 4'b1101, 4'b0000, 4'b0000);

    rst_n = 1'b0;
    btn_a = 4'b0100;
    btn_b = 4'b0000;
    btn_c = 4'b0000;
    #1;
    check("reset_deb_a", deb_a, 0);
    check("reset_rise_a", rise_a, 0);
    check("reset_deb_c", deb_c, 0);

    // Phase 1: lockout table, active-low channel, simultaneous presses.
    do_reset();
    for (int e = 1; e <= 34; e++) begin
      btn_a = tbl[e].btn;
      tick();
      check("a_deb", deb_a, tbl[e].deb);
      check("a_rise", rise_a, tbl[e].rise);
      check("a_fall", fall_a, tbl[e].fall);
      check("a_long", long_a, 0);
    end

    // Reset while ch0/ch3 timers sit at 5 with outputs high.
    rst_n = 1'b0;
    #1;
    check("midrst_deb", deb_a, 0);
    check("midrst_rise", rise_a, 0);
    check("midrst_fall", fall_a, 0);
    repeat (2) begin
      tick();
      check("inrst_deb", deb_a, 0);
      check("inrst_strobe", {rise_a, fall_a}, 0);
    end
    rst_n  = 1'b1;
    edge_n = 0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check("rel_deb", deb_a, (e >= 3) ? 4'b1101 : 4'b0000);
      check("rel_rise", rise_a, (e == 3) ? 4'b1101 : 4'b0000);
      check("rel_fall", fall_a, 0);
    end

    // Phase 2: stable mode, bounces on ch1 then a steady 1 from edge 30.
    do_reset();
    for (int e = 1; e <= 48; e++) begin
      btn_b[1] = ((e >= 21 && e <= 23) || (e >= 27 && e <= 28) || e >= 30);
      tick();
      check("b_deb", deb_b, (e >= 39) ? 4'b0010 : 4'b0000);
      check("b_rise", rise_b, (e == 39) ? 4'b0010 : 4'b0000);
      check("b_fall", fall_b, 0);
    end

    // Phase 3: long press on ch3 (rise 7, long 26), then a 10-cycle press with no long.
    do_reset();
    for (int e = 1; e <= 75; e++) begin
      btn_c[3] = ((e >= 5 && e <= 40) || (e >= 50 && e <= 59));
      tick();
      check("c_deb", deb_c, ((e >= 7 && e <= 42) || (e >= 52 && e <= 61)) ? 4'b1000 : 4'b0000);
      check("c_rise", rise_c, (e == 7 || e == 52) ? 4'b1000 : 4'b0000);
      check("c_fall", fall_c, (e == 43 || e == 62) ? 4'b1000 : 4'b0000);
      check("c_long", long_c, (e == 26) ? 4'b1000 : 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised, multi-channel successor to the single-button debouncer. Cleans NCH asynchronous mechanical inputs (buttons, switches) for the rest of the design.
- Each channel has its own 2FF synchroniser, per-channel timer, debounced level, registered rise/fall strobes and a long-press strobe.
- Two filter modes, chosen at elaboration:
  - Lockout: the first edge propagates immediately, then the channel ignores its input for a hold-off window.
  - Stable: the output changes only after the input has been steady for a full window.

Parameters:
- NCH, 4: number of independent channels.
- TIME_PERIOD, 75000: filter window in clocks; legal range ≥2.
- MODE, 0: 0 = lockout, 1 = stable.
- ACTIVE_LOW, {NCH{1'b0}}: per-channel mask. Bit set means the raw pin is inverted before synchronisation, so debounced 1 always means "pressed".
- HOLD_PERIOD, 0: clocks of continuous pressed level before o_long fires; 0 disables o_long.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_btn  in  NCH  raw asynchronous inputs
- o_debounced  out  NCH  filtered level per channel (1 = pressed)
- o_rise  out  NCH  one-clock pulse on a 0→1 change of o_debounced
- o_fall  out  NCH  one-clock pulse on a 1→0 change of o_debounced
- o_long  out  NCH  one-clock pulse once per press, after HOLD_PERIOD clocks pressed

Behaviour:
- Reset (i_rst_n low): asynchronous assert, released synchronously by the next i_clk edge. Clears all sync flops, timers, hold counters and every output to 0. Reset mid-window abandons the window; no strobe is emitted.
- Width rules:
  - Timer width = $clog2(TIME_PERIOD).
  - Hold counter width = $clog2(HOLD_PERIOD+1), minimum 1.
  - Counters never wrap: timer stops at 0, hold counter saturates at HOLD_PERIOD.
- Sync: s = sync2 output = i_btn ^ ACTIVE_LOW, delayed by 2 flops. An i_btn level present at edge k appears on s after edge k+1.
- Channels are fully independent; simultaneous events on different channels are each handled in the same cycle.
- MODE 0 (lockout), per channel:
  - Timer ≠ 0: decrement; the output is frozen.
  - Timer = 0 and s ≠ o_debounced: o_debounced <= s and timer <= TIME_PERIOD−1 on the same edge.
  - Latency: i_btn change sampled at edge k → o_debounced updates at edge k+2.
  - The next possible change is at edge k+2+TIME_PERIOD.
- MODE 1 (stable), per channel count-up counter c:
  - s = o_debounced: c <= 0.
  - Otherwise, if c = TIME_PERIOD−1: o_debounced <= s and c <= 0.
  - Otherwise: c <= c+1.
  - Latency: a change held from edge k onward → o_debounced updates at edge k+1+TIME_PERIOD.
  - Any glitch back to the old level before then restarts the count.
- Strobes: o_rise and o_fall are registered and high in exactly the cycle o_debounced first shows its new value. Never both high on one channel.
- Long press (HOLD_PERIOD > 0):
  - Hold counter clears while o_debounced = 0; increments while o_debounced = 1; saturates.
  - o_long pulses for one clock in the cycle where o_debounced has been 1 for exactly HOLD_PERIOD cycles, counting the o_rise cycle as 1.
  - At most one o_long per press. A release before that point gives no o_long.
- HOLD_PERIOD = 0: o_long is constant 0.

Test Plan:
- Defaults (NCH=4, MODE=0), TIME_PERIOD=8: raise i_btn[0] at edge 10 → o_debounced[0]=1 and o_rise[0]=1 at edge 12, o_rise low at edge 13. Drop i_btn[0] at edge 14 → o_debounced[0] stays 1 until edge 20, then falls with o_fall[0] pulse.
- MODE=1, TIME_PERIOD=8: bounce i_btn[1] 1,0,1 every 3 clocks, then hold 1 from edge 30 → o_debounced[1] rises at edge 39 only, single o_rise, no o_fall.
- ACTIVE_LOW=4'b0100: i_btn[2] held 1 from reset → o_debounced[2]=0 throughout. Drive i_btn[2]=0 → o_debounced[2]=1 with o_rise[2].
- HOLD_PERIOD=20, TIME_PERIOD=4, MODE=0: press ch3 → o_long[3] pulses exactly 19 clocks after the o_rise cycle, once. A 10-clock press gives no o_long.
- Press ch0 and ch3 in the same clock → both o_rise pulses in the same cycle; other channels stay 0.
- Assert i_rst_n low mid-window (timer=5, o_debounced=1) → all outputs 0 immediately, no strobe. After release, the still-pressed button is re-detected with o_rise 2 edges after the first sampling edge (MODE 0).
